// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-arithmetic checkers: FSM states,
// drain length and the error-width helper.
package approx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Cycles spent flushing the two-stage error pipeline after the last sample.
    localparam int DRAIN_LEN = 2;

    // An N-bit add produces N+1 bits, so the absolute error needs N+1 bits.
    function automatic int err_width(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Sample, control and report port of approx_err_monitor.
// Handshakes: a transfer happens on the rising edge where valid && ready;
// valid never waits for ready, and report fields hold while rpt_valid is high.
interface approx_err_monitor_if #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
);
    localparam int EW = approx_pkg::err_width(N);

    logic             start;
    logic [CNT_W-1:0] win_len;
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
    logic             cin;
    logic [N-1:0]     approx_sum;
    logic             approx_cout;
    logic             busy;
    logic             rpt_valid;
    logic             rpt_ready;
    logic [CNT_W-1:0] rpt_samples;
    logic [CNT_W-1:0] rpt_err_cnt;
    logic [ACC_W-1:0] rpt_err_sum;
    logic [EW-1:0]    rpt_err_max;

    modport master (
        output start, win_len, in_valid, a, b, cin, approx_sum, approx_cout, rpt_ready,
        input  in_ready, busy, rpt_valid, rpt_samples, rpt_err_cnt, rpt_err_sum, rpt_err_max
    );

    modport slave (
        input  start, win_len, in_valid, a, b, cin, approx_sum, approx_cout, rpt_ready,
        output in_ready, busy, rpt_valid, rpt_samples, rpt_err_cnt, rpt_err_sum, rpt_err_max
    );

endinterface

// File: rtl/approx_err_abs.sv
// Absolute difference between the exact sum a+b+cin and an adder's
// {cout, sum} output; purely combinational.
module approx_err_abs import approx_pkg::*; #(
    parameter int N = 8
) (
    input  logic [N-1:0]              a,
    input  logic [N-1:0]              b,
    input  logic                      cin,
    input  logic [N-1:0]              approx_sum,
    input  logic                      approx_cout,
    output logic [err_width(N)-1:0]   err
);
    localparam int EW = err_width(N);

    logic [EW-1:0] exact;
    logic [EW-1:0] approx;

    always_comb begin
        exact  = {1'b0, a} + {1'b0, b} + EW'(cin);
        approx = {approx_cout, approx_sum};
        err    = (exact >= approx) ? (exact - approx) : (approx - exact);
    end

endmodule

// File: rtl/approx_err_monitor.sv
// Windowed error statistics for an approximate adder: register sample,
// register |error|, then accumulate count / saturating sum / maximum.
module approx_err_monitor import approx_pkg::*; #(
    parameter int N     = 8,
    parameter int CNT_W = 16,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    approx_err_monitor_if.slave  mon,
    output state_t               dbg_state
);
    localparam int EW = err_width(N);
    // Sum is formed one bit wider than both addends so the clamp test is exact.
    localparam int SW = ((ACC_W > EW) ? ACC_W : EW) + 1;
    localparam logic [SW-1:0] SAT = (SW'(1) << ACC_W) - SW'(1);

    state_t           state_q, state_d;
    logic [1:0]       drain_q;
    logic [CNT_W-1:0] win_q;
    logic [CNT_W-1:0] acc_cnt_q;
    logic             accept, start_ok, last_acc;

    logic             s1_vld;
    logic [N-1:0]     s1_a, s1_b, s1_sum;
    logic             s1_cin, s1_cout;
    logic [EW-1:0]    s1_err;
    logic             s2_vld;
    logic [EW-1:0]    s2_err;

    logic [CNT_W-1:0] samples_q, err_cnt_q;
    logic [ACC_W-1:0] err_sum_q;
    logic [EW-1:0]    err_max_q;
    logic [SW-1:0]    sum_ext;

    assign accept   = mon.in_valid && (state_q == RUN);
    assign start_ok = (state_q == IDLE) && mon.start && (mon.win_len != '0);
    assign last_acc = accept && ((acc_cnt_q + CNT_W'(1)) == win_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_d       = state_q;
        mon.in_ready  = 1'b0;
        mon.busy      = 1'b1;
        mon.rpt_valid = 1'b0;
        case (state_q)
            IDLE: begin
                mon.busy = 1'b0;
                if (start_ok) state_d = RUN;
            end
            RUN: begin
                mon.in_ready = 1'b1;
                if (last_acc) state_d = DRAIN;
            end
            DRAIN: begin
                if (int'(drain_q) == DRAIN_LEN - 1) state_d = REPORT;
            end
            REPORT: begin
                mon.rpt_valid = 1'b1;
                if (mon.rpt_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbg_state = state_q;

    approx_err_abs #(.N(N)) u_abs (
        .a           (s1_a),
        .b           (s1_b),
        .cin         (s1_cin),
        .approx_sum  (s1_sum),
        .approx_cout (s1_cout),
        .err         (s1_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q     <= '0;
            acc_cnt_q <= '0;
            s1_vld    <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_cin    <= 1'b0;
            s1_sum    <= '0;
            s1_cout   <= 1'b0;
            s2_vld    <= 1'b0;
            s2_err    <= '0;
        end else begin
            if (start_ok) begin
                win_q     <= mon.win_len;
                acc_cnt_q <= '0;
            end else if (accept) begin
                acc_cnt_q <= acc_cnt_q + CNT_W'(1);
            end
            s1_vld <= accept;
            if (accept) begin
                s1_a    <= mon.a;
                s1_b    <= mon.b;
                s1_cin  <= mon.cin;
                s1_sum  <= mon.approx_sum;
                s1_cout <= mon.approx_cout;
            end
            s2_vld <= s1_vld;
            if (s1_vld) s2_err <= s1_err;
        end
    end

    assign sum_ext = SW'(err_sum_q) + SW'(s2_err);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samples_q <= '0;
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (start_ok) begin
            samples_q <= '0;
            err_cnt_q <= '0;
            err_sum_q <= '0;
            err_max_q <= '0;
        end else if (s2_vld) begin
            samples_q <= samples_q + CNT_W'(1);
            if (s2_err != '0) err_cnt_q <= err_cnt_q + CNT_W'(1);
            err_sum_q <= (sum_ext > SAT) ? '1 : ACC_W'(sum_ext);
            if (s2_err > err_max_q) err_max_q <= s2_err;
        end
    end

    assign mon.rpt_samples = samples_q;
    assign mon.rpt_err_cnt = err_cnt_q;
    assign mon.rpt_err_sum = err_sum_q;
    assign mon.rpt_err_max = err_max_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Bench for approx_err_monitor: two instances (wide and 4-bit accumulator)
// share stimulus; a reference model queues expected reports, a monitor pops them.
module tb_approx_err_monitor;
  import approx_pkg::*;

  localparam int RW = 16 + 16 + 32 + 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] win_len = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  a = '0, b = '0, apx_sum = '0;
  logic        cin = 1'b0, apx_cout = 1'b0;
  logic        rpt_ready = 1'b0;
  state_t      st0, st1;

  approx_err_monitor_if #(.N(8), .CNT_W(16), .ACC_W(32)) if0 ();
  approx_err_monitor_if #(.N(8), .CNT_W(16), .ACC_W(4))  if1 ();

  assign if0.start = start;          assign if1.start = start;
  assign if0.win_len = win_len;      assign if1.win_len = win_len;
  assign if0.in_valid = in_valid;    assign if1.in_valid = in_valid;
  assign if0.a = a;                  assign if1.a = a;
  assign if0.b = b;                  assign if1.b = b;
  assign if0.cin = cin;              assign if1.cin = cin;
  assign if0.approx_sum = apx_sum;   assign if1.approx_sum = apx_sum;
  assign if0.approx_cout = apx_cout; assign if1.approx_cout = apx_cout;
  assign if0.rpt_ready = rpt_ready;  assign if1.rpt_ready = rpt_ready;

  approx_err_monitor #(.N(8), .CNT_W(16), .ACC_W(32)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .mon(if0), .dbg_state(st0));
  approx_err_monitor #(.N(8), .CNT_W(16), .ACC_W(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .mon(if1), .dbg_state(st1));

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q0[$];
  logic [RW-1:0] exp_q1[$];
  int n_checks = 0;
  int n_fail = 0;

  function automatic logic [RW-1:0] pack(input logic [15:0] s, input logic [15:0] c,
                                         input logic [31:0] sum, input logic [8:0] mx);
    return {s, c, sum, mx};
  endfunction

  function automatic longint sat(input longint s, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (s > lim) ? lim : s;
  endfunction

  task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  int last_acc = -100;
  logic was_v[2];
  logic hs[2];
  logic [RW-1:0] snap[2];

  task automatic check_port(input int k, input logic v, input logic r, input logic [RW-1:0] act);
    logic [RW-1:0] e;
    if (hs[k]) begin
      chk($sformatf("rpt_fall%0d", k), RW'(v), RW'(0));
      hs[k] = 1'b0;
    end else if (was_v[k]) begin
      chk($sformatf("rpt_hold%0d", k), RW'(v), RW'(1));
    end
    if (v && !hs[k]) begin
      if (!was_v[k]) begin
        snap[k] = act;
        chk($sformatf("rpt_latency%0d", k), RW'(cyc - last_acc), RW'(3));
      end else begin
        chk($sformatf("rpt_stable%0d", k), act, snap[k]);
      end
      if (r) begin
        if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
          chk($sformatf("rpt_unexpected%0d", k), RW'(1), RW'(0));
        end else begin
          e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          chk($sformatf("rpt_fields%0d", k), act, e);
        end
        hs[k] = 1'b1;
      end
    end
    was_v[k] = v;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        was_v[k] = 1'b0;
        hs[k] = 1'b0;
      end
    end else begin
      cyc++;
      if (if0.in_valid && if0.in_ready) last_acc = cyc;
      check_port(0, if0.rpt_valid, if0.rpt_ready,
                 pack(if0.rpt_samples, if0.rpt_err_cnt, if0.rpt_err_sum, if0.rpt_err_max));
      check_port(1, if1.rpt_valid, if1.rpt_ready,
                 pack(if1.rpt_samples, if1.rpt_err_cnt, 32'(if1.rpt_err_sum), if1.rpt_err_max));
    end
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic gen(input int mode, input int idx, output logic [7:0] ga, output logic [7:0] gb,
                     output logic gc, output logic [8:0] gap);
    int ex, e, r;
    ga = 8'($urandom_range(0, 255));
    gb = 8'($urandom_range(0, 255));
    gc = 1'($urandom_range(0, 1));
    if (mode == 4) begin
      ga  = (idx == 0) ? 8'h0F : 8'h80;
      gb  = (idx == 0) ? 8'h01 : 8'h80;
      gc  = (idx == 0) ? 1'b0 : 1'b1;
    end
    ex = int'(ga) + int'(gb) + int'(gc);
    gap = 9'(ex);
    case (mode)
      1: begin
        r = $urandom_range(0, 3);
        if (r == 1) gap = 9'(ex) ^ 9'(1 << $urandom_range(0, 3));
        else if (r >= 2) gap = 9'(ex) ^ 9'($urandom_range(1, 511));
      end
      2, 3: begin
        e = (mode == 2) ? 7 : 3;
        gap = (ex >= e) ? 9'(ex - e) : 9'(ex + e);
      end
      4: gap = (idx == 0) ? 9'h00F : 9'h100;
      default: ;
    endcase
  endtask

  task automatic do_start(input int wl);
    start = 1'b1;
    win_len = 16'(wl);
    step();
    start = 1'b0;
  endtask

  task automatic feed_window(input int wl, input int mode, input bit rand_valid, input bit noise);
    int cnt = 0, guard = 0, m_cnt = 0, m_max = 0, ex, ap, e;
    longint m_sum = 0;
    logic [7:0] ga, gb;
    logic gc, v, rdy;
    logic [8:0] gap;
    while (cnt < wl && guard < 2000) begin
      rdy = if0.in_ready;
      v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      gen(mode, cnt, ga, gb, gc, gap);
      in_valid = v; a = ga; b = gb; cin = gc;
      apx_sum = gap[7:0]; apx_cout = gap[8];
      if (noise) begin
        start = ($urandom_range(0, 3) == 0);
        win_len = 16'($urandom_range(1, 9));
      end
      if (v && rdy) begin
        ex = int'(ga) + int'(gb) + int'(gc);
        ap = int'(gap);
        e = (ex > ap) ? ex - ap : ap - ex;
        if (e != 0) m_cnt++;
        m_sum += e;
        if (e > m_max) m_max = e;
        cnt++;
      end
      step();
      guard++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    chk("feed_count", RW'(cnt), RW'(wl));
    exp_q0.push_back(pack(16'(wl), 16'(m_cnt), 32'(sat(m_sum, 32)), 9'(m_max)));
    exp_q1.push_back(pack(16'(wl), 16'(m_cnt), 32'(sat(m_sum, 4)), 9'(m_max)));
  endtask

  task automatic wait_report(input int hold, input bit early, input bit noise);
    int g = 0;
    if (early) rpt_ready = 1'b1;
    in_valid = 1'b1;  // ignored outside RUN
    while (!if0.rpt_valid && g < 40) begin
      step();
      g++;
    end
    in_valid = 1'b0;
    if (!if0.rpt_valid) begin
      chk("rpt_timeout", RW'(if0.rpt_valid), RW'(1));
      rpt_ready = 1'b0;
      return;
    end
    if (!early) begin
      repeat (hold) begin
        if (noise) begin
          start = 1'b1;
          win_len = 16'($urandom_range(1, 9));
        end
        step();
      end
      start = 1'b0;
      rpt_ready = 1'b1;
    end
    step();
    rpt_ready = 1'b0;
    step();
    chk("idle_after_rpt", RW'(st0), RW'(IDLE));
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_in_ready0"}, RW'(if0.in_ready), RW'(0));
    chk({tag, "_busy0"}, RW'(if0.busy), RW'(0));
    chk({tag, "_rpt_valid0"}, RW'(if0.rpt_valid), RW'(0));
    chk({tag, "_busy1"}, RW'(if1.busy), RW'(0));
    chk({tag, "_rpt_valid1"}, RW'(if1.rpt_valid), RW'(0));
  endtask

  task automatic check_zero_fields(input string tag);
    chk({tag, "_fields0"}, pack(if0.rpt_samples, if0.rpt_err_cnt, if0.rpt_err_sum, if0.rpt_err_max), '0);
    chk({tag, "_fields1"}, pack(if1.rpt_samples, if1.rpt_err_cnt, 32'(if1.rpt_err_sum), if1.rpt_err_max), '0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check_zero_fields("reset");
    chk("reset_state", RW'(st0), RW'(IDLE));
    rst_n = 1'b1;
    step();

    // zero-length window is ignored
    do_start(0);
    repeat (3) step();
    check_quiet("wl0");
    chk("wl0_state", RW'(st0), RW'(IDLE));

    // exact adder: no error
    do_start(4);
    feed_window(4, 0, 1'b0, 1'b0);
    wait_report(0, 1'b0, 1'b0);

    // directed two-sample window, each err = 1
    do_start(2);
    feed_window(2, 4, 1'b0, 1'b0);
    wait_report(2, 1'b0, 1'b0);

    // err = 7 three times: 21 wide, clamps to 15 on the 4-bit accumulator
    do_start(3);
    feed_window(3, 2, 1'b0, 1'b0);
    wait_report(0, 1'b1, 1'b0);

    // random valid, start noise in RUN and REPORT, report held 5 cycles
    do_start(5);
    feed_window(5, 1, 1'b1, 1'b1);
    wait_report(5, 1'b0, 1'b1);

    for (int i = 0; i < 10; i++) begin
      int wl, mode;
      wl = $urandom_range(1, 12);
      mode = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 1;
      do_start(wl);
      feed_window(wl, mode, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_report($urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // asynchronous reset in the middle of a window
    do_start(6);
    in_valid = 1'b1;
    a = 8'h33; b = 8'h44; cin = 1'b0; apx_sum = 8'h00; apx_cout = 1'b0;
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check_quiet("midrst");
    check_zero_fields("midrst");
    chk("midrst_state", RW'(st0), RW'(IDLE));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
    do_start(1);
    feed_window(1, 3, 1'b0, 1'b0);
    wait_report(1, 1'b0, 1'b0);

    repeat (3) step();
    chk("exp_q0_empty", RW'(exp_q0.size()), RW'(0));
    chk("exp_q1_empty", RW'(exp_q1.size()), RW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
